// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decode-side operands and control in,
// registered EX-side copies, stall enables and event counters out.
interface id_ex_stage_reg_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic [4:0]       if_id_Rs1;
    logic [4:0]       if_id_Rs2;
    logic [4:0]       if_id_rd;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [XLEN-1:0]  id_read_data1;
    logic [XLEN-1:0]  id_read_data2;
    logic [XLEN-1:0]  id_imm;
    logic [XLEN-1:0]  id_pc;
    logic [8:0]       id_ctrl;
    logic             flush;
    logic [4:0]       id_ex_Rs1;
    logic [4:0]       id_ex_Rs2;
    logic [4:0]       id_ex_rd;
    logic [XLEN-1:0]  id_ex_read_data1;
    logic [XLEN-1:0]  id_ex_read_data2;
    logic [XLEN-1:0]  id_ex_imm;
    logic [XLEN-1:0]  id_ex_pc;
    logic [8:0]       id_ex_ctrl;
    logic             pc_write;
    logic             if_id_write;
    logic [CNT_W-1:0] bubble_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output if_id_Rs1, if_id_Rs2, if_id_rd,
        output id_uses_rs1, id_uses_rs2,
        output id_read_data1, id_read_data2,
        output id_imm, id_pc, id_ctrl, flush,
        input  id_ex_Rs1, id_ex_Rs2, id_ex_rd,
        input  id_ex_read_data1, id_ex_read_data2,
        input  id_ex_imm, id_ex_pc, id_ex_ctrl,
        input  pc_write, if_id_write,
        input  bubble_count, flush_count
    );

    modport slave (
        input  if_id_Rs1, if_id_Rs2, if_id_rd,
        input  id_uses_rs1, id_uses_rs2,
        input  id_read_data1, id_read_data2,
        input  id_imm, id_pc, id_ctrl, flush,
        output id_ex_Rs1, id_ex_Rs2, id_ex_rd,
        output id_ex_read_data1, id_ex_read_data2,
        output id_ex_imm, id_ex_pc, id_ex_ctrl,
        output pc_write, if_id_write,
        output bubble_count, flush_count
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall and flush bubbles.
// Ports: clk, rst (async high), bus (slave view of id_ex_stage_reg_if).
module id_ex_stage_reg #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              rst,
    id_ex_stage_reg_if.slave bus
);
    // id_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg,
    //            Branch, ALUSrc, ALUOp[1:0], valid}
    localparam int C_MEMREAD = 7;
    localparam int C_VALID   = 0;

    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_d1;
    logic [XLEN-1:0]  r_d2;
    logic [XLEN-1:0]  r_imm;
    logic [XLEN-1:0]  r_pc;
    logic [8:0]       r_ctrl;
    logic [CNT_W-1:0] r_bub_cnt;
    logic [CNT_W-1:0] r_fl_cnt;

    logic w_load_in_ex;
    logic w_dep1;
    logic w_dep2;
    logic w_hazard;
    logic w_stall;

    // A valid load in EX whose rd is consumed by the ID instruction.
    assign w_load_in_ex = r_ctrl[C_MEMREAD] & r_ctrl[C_VALID]
                        & (r_rd != 5'd0);
    assign w_dep1   = bus.id_uses_rs1 & (r_rd == bus.if_id_Rs1);
    assign w_dep2   = bus.id_uses_rs2 & (r_rd == bus.if_id_Rs2);
    assign w_hazard = w_load_in_ex & (w_dep1 | w_dep2);
    assign w_stall  = w_hazard & ~bus.flush;

    assign bus.pc_write    = ~w_stall;
    assign bus.if_id_write = ~w_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_ctrl    <= '0;
            r_bub_cnt <= '0;
            r_fl_cnt  <= '0;
        end else if (bus.flush || w_stall) begin
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_imm  <= '0;
            r_pc   <= '0;
            r_ctrl <= '0;
            // Flush wins: a coincident hazard is not a load-use bubble.
            if (bus.flush) begin
                if (r_fl_cnt != '1)
                    r_fl_cnt <= r_fl_cnt + CNT_W'(1);
            end else begin
                if (r_bub_cnt != '1)
                    r_bub_cnt <= r_bub_cnt + CNT_W'(1);
            end
        end else begin
            r_rs1  <= bus.if_id_Rs1;
            r_rs2  <= bus.if_id_Rs2;
            r_rd   <= bus.if_id_rd;
            r_d1   <= bus.id_read_data1;
            r_d2   <= bus.id_read_data2;
            r_imm  <= bus.id_imm;
            r_pc   <= bus.id_pc;
            r_ctrl <= bus.id_ctrl;
        end
    end

    assign bus.id_ex_Rs1        = r_rs1;
    assign bus.id_ex_Rs2        = r_rs2;
    assign bus.id_ex_rd         = r_rd;
    assign bus.id_ex_read_data1 = r_d1;
    assign bus.id_ex_read_data2 = r_d2;
    assign bus.id_ex_imm        = r_imm;
    assign bus.id_ex_pc         = r_pc;
    assign bus.id_ex_ctrl       = r_ctrl;
    assign bus.bubble_count     = r_bub_cnt;
    assign bus.flush_count      = r_fl_cnt;
endmodule
